// File: rtl/pad_hook_monitor.sv
// Snoops SNES CPU bus to derive auto/manual joypad-read qualifiers
// for the NMI hook branch selection.
module pad_hook_monitor #(
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] SNES_ADDR,
  input  logic [7:0]  SNES_DATA,
  input  logic        SNES_wr_strobe,
  input  logic        SNES_rd_strobe,
  input  logic        SNES_reset_strobe,
  input  logic        snescmd_unlock,
  output logic        snes_ajr,
  output logic        pad_latch,
  output logic [1:0]  mjr_state,
  output logic [4:0]  mjr_rd_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE_HI = 2'd1,
    READING   = 2'd2
  } mjr_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  mjr_t       state;
  mjr_t       state_nxt;
  logic       reload;
  logic [3:0] hold;
  logic [3:0] hold_nxt;
  logic [4:0] cnt_nxt;

  logic        clr;
  logic        sys;
  logic        live;
  logic [15:0] a16;
  logic        d0;
  logic        nmi_wr;
  logic        joy_wr;
  logic        joy_rd;
  logic        frame_tick;
  logic        unused_ok;

  assign clr  = rst | SNES_reset_strobe;
  assign sys  = ~SNES_ADDR[22];
  assign live = ~snescmd_unlock;
  assign a16  = SNES_ADDR[15:0];
  assign d0   = SNES_DATA[0];

  assign nmi_wr = SNES_wr_strobe & live & sys
                & (a16 == 16'h4200);
  assign joy_wr = SNES_wr_strobe & live & sys
                & (a16 == 16'h4016);
  assign joy_rd = SNES_rd_strobe & live & sys
                & ((a16 == 16'h4016) | (a16 == 16'h4017));

  // The NMI vector fetch marks frames even while hook code runs.
  assign frame_tick = SNES_rd_strobe
                    & (SNES_ADDR == 24'h00FFEA);

  assign unused_ok = ^SNES_DATA[7:1];

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    reload    = 1'b0;
    unique case (state)
      IDLE: begin
        if (joy_wr && d0) begin
          state_nxt = STROBE_HI;
        end
      end
      STROBE_HI: begin
        if (joy_wr && !d0) begin
          state_nxt = READING;
          reload    = 1'b1;
        end
      end
      READING: begin
        if (joy_wr && d0) begin
          state_nxt = STROBE_HI;
        end else if (frame_tick) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    hold_nxt = hold;
    if (reload) begin
      hold_nxt = HOLD_INIT;
    end else if (frame_tick && hold != 4'd0) begin
      hold_nxt = hold - 4'd1;
    end
  end

  always_comb begin
    cnt_nxt = mjr_rd_cnt;
    if (reload) begin
      cnt_nxt = 5'd0;
    end else if (state == READING && joy_rd
                 && mjr_rd_cnt != CNT_MAX) begin
      cnt_nxt = mjr_rd_cnt + 5'd1;
    end
  end

  // pad_latch follows the next hold value so it moves with the strobe.
  always_ff @(posedge clk) begin
    if (clr) begin
      hold       <= 4'd0;
      pad_latch  <= 1'b0;
      mjr_rd_cnt <= 5'd0;
      snes_ajr   <= 1'b0;
    end else begin
      hold       <= hold_nxt;
      pad_latch  <= (hold_nxt != 4'd0);
      mjr_rd_cnt <= cnt_nxt;
      if (nmi_wr) begin
        snes_ajr <= d0;
      end
    end
  end

  assign mjr_state = state;

endmodule

// File: tb/tb_pad_hook_monitor.sv
// Directed bench for pad_hook_monitor: reset, auto-read flag,
// manual strobe FSM, read counter, hold timing and masking.
module tb_pad_hook_monitor;

  logic        clk;
  logic        rst;
  logic [23:0] SNES_ADDR;
  logic [7:0]  SNES_DATA;
  logic        SNES_wr_strobe;
  logic        SNES_rd_strobe;
  logic        SNES_reset_strobe;
  logic        snescmd_unlock;
  logic        snes_ajr;
  logic        pad_latch;
  logic [1:0]  mjr_state;
  logic [4:0]  mjr_rd_cnt;

  int n_cmp;
  int n_bad;

  pad_hook_monitor #(.HOLD_FRAMES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .SNES_ADDR         (SNES_ADDR),
    .SNES_DATA         (SNES_DATA),
    .SNES_wr_strobe    (SNES_wr_strobe),
    .SNES_rd_strobe    (SNES_rd_strobe),
    .SNES_reset_strobe (SNES_reset_strobe),
    .snescmd_unlock    (snescmd_unlock),
    .snes_ajr          (snes_ajr),
    .pad_latch         (pad_latch),
    .mjr_state         (mjr_state),
    .mjr_rd_cnt        (mjr_rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    SNES_ADDR      = a;
    SNES_DATA      = d;
    SNES_wr_strobe = 1'b1;
    @(negedge clk);
    SNES_wr_strobe = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a);
    @(negedge clk);
    SNES_ADDR      = a;
    SNES_rd_strobe = 1'b1;
    @(negedge clk);
    SNES_rd_strobe = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_creset();
    @(negedge clk);
    SNES_reset_strobe = 1'b1;
    @(negedge clk);
    SNES_reset_strobe = 1'b0;
  endtask

  task automatic test_reset();
    pulse_rst();
    n_cmp++;
    if (snes_ajr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ajr got %b want 0", snes_ajr);
    end
    n_cmp++;
    if (pad_latch !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_latch got %b want 0", pad_latch);
    end
    n_cmp++;
    if (mjr_state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state got %0d want 0", mjr_state);
    end
    n_cmp++;
    if (mjr_rd_cnt !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d want 0", mjr_rd_cnt);
    end
  endtask

  task automatic test_ajr();
    wr(24'h004200, 8'h81);
    n_cmp++;
    if (snes_ajr !== 1'b1) begin
      n_bad++;
      $display("FAIL ajr_set got %b want 1", snes_ajr);
    end
    wr(24'h004200, 8'h80);
    n_cmp++;
    if (snes_ajr !== 1'b0) begin
      n_bad++;
      $display("FAIL ajr_clr got %b want 0", snes_ajr);
    end
    wr(24'h804200, 8'h01);
    n_cmp++;
    if (snes_ajr !== 1'b1) begin
      n_bad++;
      $display("FAIL ajr_mirror got %b want 1", snes_ajr);
    end
    wr(24'h404200, 8'h00);
    n_cmp++;
    if (snes_ajr !== 1'b1) begin
      n_bad++;
      $display("FAIL ajr_nonsys got %b want 1", snes_ajr);
    end
  endtask

  task automatic test_strobe_count();
    wr(24'h004016, 8'h01);
    n_cmp++;
    if (mjr_state !== 2'd1) begin
      n_bad++;
      $display("FAIL strobe_hi got %0d want 1", mjr_state);
    end
    n_cmp++;
    if (pad_latch !== 1'b0) begin
      n_bad++;
      $display("FAIL strobe_hi_latch got %b want 0", pad_latch);
    end
    wr(24'h004016, 8'h00);
    n_cmp++;
    if (mjr_state !== 2'd2) begin
      n_bad++;
      $display("FAIL reading got %0d want 2", mjr_state);
    end
    n_cmp++;
    if (pad_latch !== 1'b1) begin
      n_bad++;
      $display("FAIL latch_rise got %b want 1", pad_latch);
    end
    for (int i = 0; i < 8; i++) rd(24'h004016);
    for (int i = 0; i < 8; i++) rd(24'h804017);
    n_cmp++;
    if (mjr_rd_cnt !== 5'd16) begin
      n_bad++;
      $display("FAIL cnt16 got %0d want 16", mjr_rd_cnt);
    end
    rd(24'h404016);
    n_cmp++;
    if (mjr_rd_cnt !== 5'd16) begin
      n_bad++;
      $display("FAIL cnt_nonsys got %0d want 16", mjr_rd_cnt);
    end
    for (int i = 0; i < 14; i++) rd(24'h004016);
    n_cmp++;
    if (mjr_rd_cnt !== 5'd30) begin
      n_bad++;
      $display("FAIL cnt30 got %0d want 30", mjr_rd_cnt);
    end
    for (int i = 0; i < 10; i++) rd(24'h004016);
    n_cmp++;
    if (mjr_rd_cnt !== 5'd31) begin
      n_bad++;
      $display("FAIL cnt_sat got %0d want 31", mjr_rd_cnt);
    end
  endtask

  task automatic test_frames();
    rd(24'h00FFEA);
    n_cmp++;
    if (pad_latch !== 1'b1) begin
      n_bad++;
      $display("FAIL frame1_latch got %b want 1", pad_latch);
    end
    n_cmp++;
    if (mjr_state !== 2'd0) begin
      n_bad++;
      $display("FAIL frame1_state got %0d want 0", mjr_state);
    end
    rd(24'h80FFEA);
    n_cmp++;
    if (pad_latch !== 1'b1) begin
      n_bad++;
      $display("FAIL mirror_vec_latch got %b want 1", pad_latch);
    end
    rd(24'h00FFEA);
    n_cmp++;
    if (pad_latch !== 1'b0) begin
      n_bad++;
      $display("FAIL frame2_latch got %b want 0", pad_latch);
    end
  endtask

  task automatic test_mask();
    wr(24'h004200, 8'h00);
    n_cmp++;
    if (snes_ajr !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_pre_ajr got %b want 0", snes_ajr);
    end
    snescmd_unlock = 1'b1;
    wr(24'h004016, 8'h01);
    n_cmp++;
    if (mjr_state !== 2'd0) begin
      n_bad++;
      $display("FAIL mask_state1 got %0d want 0", mjr_state);
    end
    wr(24'h004016, 8'h00);
    wr(24'h004200, 8'h01);
    snescmd_unlock = 1'b0;
    n_cmp++;
    if (mjr_state !== 2'd0) begin
      n_bad++;
      $display("FAIL mask_state2 got %0d want 0", mjr_state);
    end
    n_cmp++;
    if (pad_latch !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_latch got %b want 0", pad_latch);
    end
    n_cmp++;
    if (snes_ajr !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_ajr got %b want 0", snes_ajr);
    end
  endtask

  task automatic test_console_reset();
    wr(24'h004200, 8'h01);
    wr(24'h004016, 8'h01);
    wr(24'h004016, 8'h00);
    wr(24'h004016, 8'h01);
    n_cmp++;
    if (mjr_state !== 2'd1 || pad_latch !== 1'b1) begin
      n_bad++;
      $display("FAIL cr_pre got %0d/%b want 1/1",
               mjr_state, pad_latch);
    end
    pulse_creset();
    n_cmp++;
    if (mjr_state !== 2'd0 || pad_latch !== 1'b0
        || snes_ajr !== 1'b0) begin
      n_bad++;
      $display("FAIL cr_post got %0d/%b/%b want 0/0/0",
               mjr_state, pad_latch, snes_ajr);
    end
    wr(24'h004200, 8'h01);
    wr(24'h004016, 8'h01);
    wr(24'h004016, 8'h00);
    wr(24'h004016, 8'h01);
    pulse_rst();
    n_cmp++;
    if (mjr_state !== 2'd0 || pad_latch !== 1'b0
        || snes_ajr !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_post got %0d/%b/%b want 0/0/0",
               mjr_state, pad_latch, snes_ajr);
    end
  endtask

  task automatic test_reload();
    wr(24'h004016, 8'h01);
    wr(24'h004016, 8'h00);
    rd(24'h00FFEA);
    n_cmp++;
    if (pad_latch !== 1'b1 || mjr_state !== 2'd0) begin
      n_bad++;
      $display("FAIL rl_tick1 got %b/%0d want 1/0",
               pad_latch, mjr_state);
    end
    wr(24'h004016, 8'h01);
    wr(24'h004016, 8'h00);
    rd(24'h00FFEA);
    n_cmp++;
    if (pad_latch !== 1'b1) begin
      n_bad++;
      $display("FAIL rl_tick2 got %b want 1", pad_latch);
    end
    rd(24'h00FFEA);
    n_cmp++;
    if (pad_latch !== 1'b0) begin
      n_bad++;
      $display("FAIL rl_tick3 got %b want 0", pad_latch);
    end
    rd(24'h00FFEA);
    n_cmp++;
    if (pad_latch !== 1'b0) begin
      n_bad++;
      $display("FAIL rl_nowrap got %b want 0", pad_latch);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    SNES_ADDR      = 24'h004016;
    SNES_DATA      = 8'h01;
    SNES_wr_strobe = 1'b1;
    @(negedge clk);
    SNES_DATA      = 8'h00;
    @(negedge clk);
    SNES_wr_strobe = 1'b0;
    SNES_rd_strobe = 1'b1;
    @(negedge clk);
    SNES_ADDR      = 24'h004017;
    @(negedge clk);
    SNES_rd_strobe = 1'b0;
    n_cmp++;
    if (mjr_state !== 2'd2 || mjr_rd_cnt !== 5'd2) begin
      n_bad++;
      $display("FAIL b2b got %0d/%0d want 2/2",
               mjr_state, mjr_rd_cnt);
    end
  endtask

  initial begin
    n_cmp             = 0;
    n_bad             = 0;
    rst               = 1'b1;
    SNES_ADDR         = 24'h0;
    SNES_DATA         = 8'h0;
    SNES_wr_strobe    = 1'b0;
    SNES_rd_strobe    = 1'b0;
    SNES_reset_strobe = 1'b0;
    snescmd_unlock    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ajr();
    test_strobe_count();
    test_frames();
    test_mask();
    test_console_reset();
    test_reload();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
